// File: rtl/jump_ctrl.sv
// jump_ctrl -- PC redirect sequencer for taken branches/jumps and traps.
// A request captured in IDLE is presented to fetch in REDIRECT until fetch
// accepts it (and no bus hold is pending), then the front-end stages are
// flushed for FLUSH_CYCLES cycles before the block returns to IDLE.
// Optional feature: define JUMP_CTRL_INT_EN to add interrupt arbitration
// (interrupt beats jump, return address capture, one-cycle acknowledge).
// Without it int_req_i/int_addr_i are ignored and int_ack_o/int_epc_o are 0.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module jump_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2  // legal range 1..7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   jump_we_i,
  input  logic [`ADDR_WIDTH-1:0] jump_addr_i,
  input  logic [`ADDR_WIDTH-1:0] exe_pc_i,
  input  logic                   int_req_i,
  input  logic [`ADDR_WIDTH-1:0] int_addr_i,
  input  logic                   hold_req_i,
  input  logic                   fetch_ready_i,
  output logic                   pc_we_o,
  output logic [`ADDR_WIDTH-1:0] pc_addr_o,
  output logic                   flush_o,
  output logic                   hold_o,
  output logic                   int_ack_o,
  output logic [`ADDR_WIDTH-1:0] int_epc_o
);

  localparam int unsigned AW       = `ADDR_WIDTH;
  localparam logic [2:0]  CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t          state_q, state_nxt;
  logic [2:0]      cnt_q, cnt_nxt;
  logic            pc_we_nxt;
  logic            flush_nxt;
  logic [AW-1:0]   pc_addr_nxt;

`ifdef JUMP_CTRL_INT_EN
  logic            int_ack_nxt;
  logic [AW-1:0]   int_epc_nxt;
`else
  // Interrupt inputs (and the execute PC, only needed for the return
  // address) have no function in a jump-only build.
  logic            unused_int;
  assign unused_int = ^{int_req_i, int_addr_i, exe_pc_i};
  assign int_ack_o  = 1'b0;
  assign int_epc_o  = '0;
`endif

  // Stall the pipeline on a bus hold, except while a redirect is being
  // presented: the redirect itself already waits for the hold to clear.
  assign hold_o = hold_req_i && !rst_i && (state_q != REDIRECT);

  // Next-state, next-counter and next-value of every registered output.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    pc_addr_nxt = pc_addr_o;
`ifdef JUMP_CTRL_INT_EN
    int_ack_nxt = 1'b0;
    int_epc_nxt = int_epc_o;
`endif

    case (state_q)
      IDLE: begin
`ifdef JUMP_CTRL_INT_EN
        // A trap wins; a jump in the same cycle is dropped but its target is
        // where execution would have resumed, so it becomes the return address.
        if (int_req_i) begin
          state_nxt   = REDIRECT;
          pc_addr_nxt = int_addr_i;
          int_ack_nxt = 1'b1;
          int_epc_nxt = jump_we_i ? jump_addr_i : exe_pc_i;
        end else
`endif
        if (jump_we_i) begin
          state_nxt   = REDIRECT;
          pc_addr_nxt = jump_addr_i;
        end
      end

      REDIRECT: begin
        if (fetch_ready_i && !hold_req_i) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_INIT;
        end
      end

      FLUSH: begin
        // The counter keeps running through a hold: flushed stages carry
        // nothing worth waiting for.
        if (cnt_q == 3'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q - 3'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase

    pc_we_nxt = (state_nxt == REDIRECT);
    flush_nxt = (state_nxt != IDLE);
  end

  // State, counter and registered outputs; synchronous reset aborts any
  // redirect or flush in progress.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the values
    // that existed before this edge, independent of statement order.
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      pc_we_o   <= 1'b0;
      flush_o   <= 1'b0;
      pc_addr_o <= '0;
`ifdef JUMP_CTRL_INT_EN
      int_ack_o <= 1'b0;
      int_epc_o <= '0;
`endif
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      pc_we_o   <= pc_we_nxt;
      flush_o   <= flush_nxt;
      pc_addr_o <= pc_addr_nxt;
`ifdef JUMP_CTRL_INT_EN
      int_ack_o <= int_ack_nxt;
      int_epc_o <= int_epc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// tb_jump_ctrl -- directed bench for jump_ctrl. Three instances share one
// set of inputs: FLUSH_CYCLES = 2 (main checks), 4 and 1 (flush length and
// mid-flush reset). Interrupt scenarios follow the JUMP_CTRL_INT_EN build.

`timescale 1ns/1ps

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_jump_ctrl;

  localparam int AW = `ADDR_WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          jump_we_i;
  logic [AW-1:0] jump_addr_i;
  logic [AW-1:0] exe_pc_i;
  logic          int_req_i;
  logic [AW-1:0] int_addr_i;
  logic          hold_req_i;
  logic          fetch_ready_i;

  // FLUSH_CYCLES = 2 instance
  logic          pc_we, flush, hold, int_ack;
  logic [AW-1:0] pc_addr, int_epc;
  // FLUSH_CYCLES = 4 instance
  logic          b_pc_we, b_flush, b_hold, b_int_ack;
  logic [AW-1:0] b_pc_addr, b_int_epc;
  // FLUSH_CYCLES = 1 instance
  logic          c_pc_we, c_flush, c_hold, c_int_ack;
  logic [AW-1:0] c_pc_addr, c_int_epc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  jump_ctrl #(.FLUSH_CYCLES(2)) u_fc2 (
    .clk_i(clk_i), .rst_i(rst_i), .jump_we_i(jump_we_i), .jump_addr_i(jump_addr_i),
    .exe_pc_i(exe_pc_i), .int_req_i(int_req_i), .int_addr_i(int_addr_i),
    .hold_req_i(hold_req_i), .fetch_ready_i(fetch_ready_i),
    .pc_we_o(pc_we), .pc_addr_o(pc_addr), .flush_o(flush), .hold_o(hold),
    .int_ack_o(int_ack), .int_epc_o(int_epc)
  );

  jump_ctrl #(.FLUSH_CYCLES(4)) u_fc4 (
    .clk_i(clk_i), .rst_i(rst_i), .jump_we_i(jump_we_i), .jump_addr_i(jump_addr_i),
    .exe_pc_i(exe_pc_i), .int_req_i(int_req_i), .int_addr_i(int_addr_i),
    .hold_req_i(hold_req_i), .fetch_ready_i(fetch_ready_i),
    .pc_we_o(b_pc_we), .pc_addr_o(b_pc_addr), .flush_o(b_flush), .hold_o(b_hold),
    .int_ack_o(b_int_ack), .int_epc_o(b_int_epc)
  );

  jump_ctrl #(.FLUSH_CYCLES(1)) u_fc1 (
    .clk_i(clk_i), .rst_i(rst_i), .jump_we_i(jump_we_i), .jump_addr_i(jump_addr_i),
    .exe_pc_i(exe_pc_i), .int_req_i(int_req_i), .int_addr_i(int_addr_i),
    .hold_req_i(hold_req_i), .fetch_ready_i(fetch_ready_i),
    .pc_we_o(c_pc_we), .pc_addr_o(c_pc_addr), .flush_o(c_flush), .hold_o(c_hold),
    .int_ack_o(c_int_ack), .int_epc_o(c_int_epc)
  );

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    jump_we_i     = 1'b0;
    jump_addr_i   = '0;
    exe_pc_i      = '0;
    int_req_i     = 1'b0;
    int_addr_i    = '0;
    hold_req_i    = 1'b0;
    fetch_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    hold_req_i = 1'b1;
    jump_we_i = 1'b1;
    jump_addr_i = 'h123;
    fetch_ready_i = 1'b1;
    tick();
    tick();
    n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL reset_pc_we: actual %0h expected 0", pc_we); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: actual %0h expected 0", flush); end
    n_checks++; if (pc_addr !== '0) begin n_fail++; $display("FAIL reset_pc_addr: actual %0h expected 0", pc_addr); end
    n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: actual %0h expected 0", hold); end
    n_checks++; if (int_ack !== 1'b0) begin n_fail++; $display("FAIL reset_int_ack: actual %0h expected 0", int_ack); end
    n_checks++; if (int_epc !== '0) begin n_fail++; $display("FAIL reset_int_epc: actual %0h expected 0", int_epc); end
    rst_i = 1'b0;
    clear_inputs();
    tick();
    n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL reset_idle_pc_we: actual %0h expected 0", pc_we); end
  endtask

  task automatic test_jump();
    do_reset();
    fetch_ready_i = 1'b1;
    jump_we_i = 1'b1;
    jump_addr_i = 'h100;
    tick();  // captured -> REDIRECT
    n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL jump_pc_we: actual %0h expected 1", pc_we); end
    n_checks++; if (pc_addr !== AW'('h100)) begin n_fail++; $display("FAIL jump_pc_addr: actual %0h expected 100", pc_addr); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jump_redirect_flush: actual %0h expected 1", flush); end
    jump_addr_i = 'h300;  // must be ignored outside IDLE
    tick();  // FLUSH 1
    n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL jump_flush1_pc_we: actual %0h expected 0", pc_we); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jump_flush1_flush: actual %0h expected 1", flush); end
    tick();  // FLUSH 2
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jump_flush2_flush: actual %0h expected 1", flush); end
    n_checks++; if (pc_addr !== AW'('h100)) begin n_fail++; $display("FAIL jump_ignored_addr: actual %0h expected 100", pc_addr); end
    jump_we_i = 1'b0;
    tick();  // IDLE
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jump_idle_flush: actual %0h expected 0", flush); end
    n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL jump_idle_pc_we: actual %0h expected 0", pc_we); end
  endtask

  // Jump issued in the very first IDLE cycle after a flush.
  task automatic test_back_to_back();
    jump_we_i = 1'b1;
    jump_addr_i = 'h400;
    fetch_ready_i = 1'b1;
    tick();
    n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL b2b_pc_we: actual %0h expected 1", pc_we); end
    n_checks++; if (pc_addr !== AW'('h400)) begin n_fail++; $display("FAIL b2b_pc_addr: actual %0h expected 400", pc_addr); end
    jump_we_i = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_flush: actual %0h expected 0", flush); end
  endtask

  // Redirect held 3 cycles by fetch, 1 by bus hold: 5 cycles of pc_we.
  task automatic test_stall_and_hold();
    do_reset();
    jump_we_i = 1'b1;
    jump_addr_i = 'h240;
    tick();
    jump_we_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_ready_i = (i >= 3);
      hold_req_i = (i == 3);
      #1;
      n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL stall_pc_we[%0d]: actual %0h expected 1", i, pc_we); end
      n_checks++; if (pc_addr !== AW'('h240)) begin n_fail++; $display("FAIL stall_pc_addr[%0d]: actual %0h expected 240", i, pc_addr); end
      if (i == 3) begin
        n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL stall_redirect_hold: actual %0h expected 0", hold); end
      end
      tick();
    end
    n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL stall_flush_pc_we: actual %0h expected 0", pc_we); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL stall_flush_flush: actual %0h expected 1", flush); end
    hold_req_i = 1'b1;
    #1;
    n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL hold_in_flush: actual %0h expected 1", hold); end
    tick();  // FLUSH 2, counter advanced despite hold
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL hold_flush2: actual %0h expected 1", flush); end
    tick();  // IDLE
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL hold_flush_end: actual %0h expected 0", flush); end
    n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL hold_in_idle: actual %0h expected 1", hold); end
    hold_req_i = 1'b0;
    #1;
    n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL hold_release: actual %0h expected 0", hold); end
  endtask

  // Flush length for FLUSH_CYCLES = 2, 4 and 1.
  task automatic test_flush_len();
    int n2 = 0;
    int n4 = 0;
    int n1 = 0;
    do_reset();
    fetch_ready_i = 1'b1;
    jump_we_i = 1'b1;
    jump_addr_i = 'h10;
    tick();
    jump_we_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (flush && !pc_we) n2++;
      if (b_flush && !b_pc_we) n4++;
      if (c_flush && !c_pc_we) n1++;
    end
    n_checks++; if (n2 != 2) begin n_fail++; $display("FAIL flush_len_2: actual %0d expected 2", n2); end
    n_checks++; if (n4 != 4) begin n_fail++; $display("FAIL flush_len_4: actual %0d expected 4", n4); end
    n_checks++; if (n1 != 1) begin n_fail++; $display("FAIL flush_len_1: actual %0d expected 1", n1); end
  endtask

  // Reset in the second FLUSH cycle of the FLUSH_CYCLES = 4 instance.
  task automatic test_reset_mid_flush();
    do_reset();
    fetch_ready_i = 1'b1;
    jump_we_i = 1'b1;
    jump_addr_i = 'h500;
    tick();  // REDIRECT
    jump_we_i = 1'b0;
    tick();  // FLUSH 1
    tick();  // FLUSH 2
    n_checks++; if (b_flush !== 1'b1) begin n_fail++; $display("FAIL rstfl_pre_flush: actual %0h expected 1", b_flush); end
    rst_i = 1'b1;
    hold_req_i = 1'b1;
    tick();
    n_checks++; if (b_flush !== 1'b0) begin n_fail++; $display("FAIL rstfl_flush: actual %0h expected 0", b_flush); end
    n_checks++; if (b_pc_we !== 1'b0) begin n_fail++; $display("FAIL rstfl_pc_we: actual %0h expected 0", b_pc_we); end
    n_checks++; if (b_pc_addr !== '0) begin n_fail++; $display("FAIL rstfl_pc_addr: actual %0h expected 0", b_pc_addr); end
    n_checks++; if (b_hold !== 1'b0) begin n_fail++; $display("FAIL rstfl_hold: actual %0h expected 0", b_hold); end
    n_checks++; if (b_int_ack !== 1'b0) begin n_fail++; $display("FAIL rstfl_int_ack: actual %0h expected 0", b_int_ack); end
    rst_i = 1'b0;
    hold_req_i = 1'b0;
    tick();
    n_checks++; if (b_flush !== 1'b0) begin n_fail++; $display("FAIL rstfl_stays_idle: actual %0h expected 0", b_flush); end
  endtask

`ifdef JUMP_CTRL_INT_EN
  task automatic test_int_priority();
    do_reset();
    fetch_ready_i = 1'b1;
    int_req_i = 1'b1;
    int_addr_i = 'h80;
    jump_we_i = 1'b1;
    jump_addr_i = 'h200;
    exe_pc_i = 'h3c;
    tick();
    n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL intpri_pc_we: actual %0h expected 1", pc_we); end
    n_checks++; if (pc_addr !== AW'('h80)) begin n_fail++; $display("FAIL intpri_pc_addr: actual %0h expected 80", pc_addr); end
    n_checks++; if (int_epc !== AW'('h200)) begin n_fail++; $display("FAIL intpri_epc: actual %0h expected 200", int_epc); end
    n_checks++; if (int_ack !== 1'b1) begin n_fail++; $display("FAIL intpri_ack: actual %0h expected 1", int_ack); end
    int_req_i = 1'b0;
    jump_we_i = 1'b0;
    tick();
    n_checks++; if (int_ack !== 1'b0) begin n_fail++; $display("FAIL intpri_ack_pulse: actual %0h expected 0", int_ack); end
    n_checks++; if (int_epc !== AW'('h200)) begin n_fail++; $display("FAIL intpri_epc_held: actual %0h expected 200", int_epc); end
    tick();
    tick();
  endtask

  task automatic test_int_pending();
    do_reset();
    fetch_ready_i = 1'b1;
    jump_we_i = 1'b1;
    jump_addr_i = 'h100;
    tick();  // REDIRECT
    jump_we_i = 1'b0;
    tick();  // FLUSH 1
    int_req_i = 1'b1;
    int_addr_i = 'h90;
    exe_pc_i = 'h5c;
    tick();  // FLUSH 2
    n_checks++; if (int_ack !== 1'b0) begin n_fail++; $display("FAIL intpend_flush_ack: actual %0h expected 0", int_ack); end
    tick();  // IDLE, request still pending
    n_checks++; if (int_ack !== 1'b0) begin n_fail++; $display("FAIL intpend_idle_ack: actual %0h expected 0", int_ack); end
    n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL intpend_idle_pc_we: actual %0h expected 0", pc_we); end
    tick();  // taken
    n_checks++; if (int_ack !== 1'b1) begin n_fail++; $display("FAIL intpend_ack: actual %0h expected 1", int_ack); end
    n_checks++; if (pc_addr !== AW'('h90)) begin n_fail++; $display("FAIL intpend_pc_addr: actual %0h expected 90", pc_addr); end
    n_checks++; if (int_epc !== AW'('h5c)) begin n_fail++; $display("FAIL intpend_epc: actual %0h expected 5c", int_epc); end
    int_req_i = 1'b0;
    tick();
    tick();
    tick();  // IDLE
    jump_we_i = 1'b1;
    jump_addr_i = 'h600;
    exe_pc_i = 'h70;
    tick();
    n_checks++; if (pc_addr !== AW'('h600)) begin n_fail++; $display("FAIL intpend_jump_addr: actual %0h expected 600", pc_addr); end
    n_checks++; if (int_epc !== AW'('h5c)) begin n_fail++; $display("FAIL intpend_epc_kept: actual %0h expected 5c", int_epc); end
    jump_we_i = 1'b0;
  endtask
`else
  task automatic test_int_disabled();
    do_reset();
    fetch_ready_i = 1'b1;
    int_req_i = 1'b1;
    int_addr_i = 'h80;
    exe_pc_i = 'h44;
    tick();
    tick();
    n_checks++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL intdis_pc_we: actual %0h expected 0", pc_we); end
    n_checks++; if (int_ack !== 1'b0) begin n_fail++; $display("FAIL intdis_ack: actual %0h expected 0", int_ack); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL intdis_flush: actual %0h expected 0", flush); end
    jump_we_i = 1'b1;
    jump_addr_i = 'h200;
    tick();
    n_checks++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL intdis_jump_pc_we: actual %0h expected 1", pc_we); end
    n_checks++; if (pc_addr !== AW'('h200)) begin n_fail++; $display("FAIL intdis_jump_addr: actual %0h expected 200", pc_addr); end
    n_checks++; if (int_ack !== 1'b0) begin n_fail++; $display("FAIL intdis_jump_ack: actual %0h expected 0", int_ack); end
    n_checks++; if (int_epc !== '0) begin n_fail++; $display("FAIL intdis_epc: actual %0h expected 0", int_epc); end
    clear_inputs();
    tick();
    tick();
    tick();
  endtask
`endif

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_jump();
    test_back_to_back();
    test_stall_and_hold();
    test_flush_len();
    test_reset_mid_flush();
`ifdef JUMP_CTRL_INT_EN
    test_int_priority();
    test_int_pending();
`else
    test_int_disabled();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of post-redirect flush cycles (legal range 1..7).
REQ-002 clk_i  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 jump_we_i  input  1  branch/jump taken from the execute-stage branch unit.
REQ-005 jump_addr_i  input  `ADDR_WIDTH  branch/jump target.
REQ-006 exe_pc_i  input  `ADDR_WIDTH  address of the instruction currently in execute.
REQ-007 int_req_i  input  1  interrupt/trap request, level, held by the source until acknowledged.
REQ-008 int_addr_i  input  `ADDR_WIDTH  trap handler vector.
REQ-009 hold_req_i  input  1  bus/memory stall request.
REQ-010 fetch_ready_i  input  1  fetch unit accepts the PC redirect this cycle.
REQ-011 pc_we_o  output  1  PC redirect valid.
REQ-012 pc_addr_o  output  `ADDR_WIDTH  redirect target.
REQ-013 flush_o  output  1  flush the IF/ID and ID/EX stages.
REQ-014 hold_o  output  1  freeze PC and pipeline registers.
REQ-015 int_ack_o  output  1  one-cycle interrupt acknowledge.
REQ-016 int_epc_o  output  `ADDR_WIDTH  return address captured for the taken interrupt.

Function
REQ-017 The block SHALL implement a state machine with states IDLE, REDIRECT and FLUSH, and a 3-bit flush counter.
REQ-018 In IDLE, an asserted request SHALL be captured at the clock edge and the state SHALL move to REDIRECT, which adds one cycle of latency.
REQ-019 Priority SHALL be int_req_i over jump_we_i; a simultaneous jump SHALL be discarded.
REQ-020 On interrupt capture: pc_addr_o <= int_addr_i; int_epc_o <= jump_we_i ? jump_addr_i : exe_pc_i; int_ack_o SHALL be high for exactly the following cycle.
REQ-021 On jump capture: pc_addr_o <= jump_addr_i; int_epc_o SHALL be unchanged.
REQ-022 In REDIRECT: pc_we_o=1, flush_o=1, hold_o=0; the state SHALL stay in REDIRECT while !(fetch_ready_i && !hold_req_i).
REQ-023 On a REDIRECT cycle with fetch_ready_i=1 and hold_req_i=0, the next state SHALL be FLUSH with counter <= FLUSH_CYCLES-1.
REQ-024 In FLUSH: pc_we_o=0, flush_o=1; the counter SHALL decrement each cycle, and the state SHALL return to IDLE on the edge where counter==0, so FLUSH lasts exactly FLUSH_CYCLES cycles.
REQ-025 In IDLE: pc_we_o=0, flush_o=0.
REQ-026 hold_o SHALL equal hold_req_i in IDLE and FLUSH; the counter SHALL still advance during a hold.
REQ-027 jump_we_i SHALL be ignored outside IDLE, because the issuing instruction is being flushed.
REQ-028 An int_req_i arriving outside IDLE SHALL stay pending and be taken on the first IDLE cycle.
REQ-029 All outputs except hold_o SHALL be registered; hold_o SHALL be combinational from hold_req_i and the state.

Reset
REQ-030 While rst_i=1 at an edge: state <= IDLE; counter, pc_we_o, flush_o, int_ack_o, pc_addr_o and int_epc_o <= 0.
REQ-031 A reset asserted mid-REDIRECT or mid-FLUSH SHALL abort the operation; a pending interrupt SHALL be re-evaluated after reset.
REQ-032 hold_o SHALL be 0 while rst_i=1.

Configuration
REQ-033 With macro JUMP_CTRL_INT_EN defined, interrupt arbitration per REQ-019/020/028 SHALL be present.
REQ-034 Without JUMP_CTRL_INT_EN, int_req_i and int_addr_i SHALL be ignored, int_ack_o and int_epc_o SHALL be tied 0, and only jumps are sequenced.

Verification
REQ-035 Reset, then jump_we_i=1 with jump_addr_i=0x100 and fetch_ready_i=1 -> next cycle pc_we_o=1 and pc_addr_o=0x100; then 2 cycles of flush_o=1 with pc_we_o=0; then IDLE.
REQ-036 Simultaneous int_req_i=1 (int_addr_i=0x80), jump_we_i=1 (0x200) -> pc_addr_o=0x80, int_epc_o=0x200, int_ack_o pulses 1 cycle.
REQ-037 REDIRECT with fetch_ready_i=0 for 3 cycles, then hold_req_i=1 for 1 cycle -> pc_we_o stays 1 for 5 cycles with pc_addr_o stable.
REQ-038 int_req_i raised during FLUSH -> no ack until IDLE; taken on the first IDLE cycle with int_epc_o=exe_pc_i.
REQ-039 rst_i=1 in the second FLUSH cycle with FLUSH_CYCLES=4 -> next cycle all outputs 0 and the state is IDLE.
REQ-040 Build without JUMP_CTRL_INT_EN and drive int_req_i=1 -> int_ack_o=0, no redirect, and jumps still work.
